shot_sequencer: RTL and testbench

- Per-frame ball-trajectory controller that drives the ball_x/ball_y inputs of the pixel generator.
- On a launch request it steps a discrete projectile model once per video frame and detects hoop score or miss.
- After the shot ends it holds the final picture for a fixed number of frames, then re-arms at the start position.
- Sits between the button/velocity inputs and the pixel generator, clocked by the 25 MHz pixel clock.

---
 rtl/shot_sequencer_if.sv | 24 ++
 rtl/shot_sequencer.sv | 176 +++++++++++++++++
 tb/tb_shot_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/shot_sequencer_if.sv
// Launch/trajectory bundle between the control source and the shot sequencer.
// The master drives the launch request and frame timing; the slave reports ball position and shot result.
interface shot_sequencer_if;
    logic       frame_tick;
    logic       launch;
    logic [5:0] vx0;
    logic [6:0] vy0;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       in_flight;
    logic       scored;
    logic       missed;
    logic       done;

    modport master (
        output frame_tick, launch, vx0, vy0,
        input  ball_x, ball_y, in_flight, scored, missed, done
    );

    modport slave (
        input  frame_tick, launch, vx0, vy0,
        output ball_x, ball_y, in_flight, scored, missed, done
    );
endinterface

// File: rtl/shot_sequencer.sv
// Per-frame projectile stepper: launches from rest, advances once per frame_tick,
// detects hoop score or miss, holds the result for HOLD_FRAMES frames, then re-arms.
module shot_sequencer #(
    parameter int START_X     = 10,
    parameter int START_Y     = 300,
    parameter int GRAVITY     = 1,
    parameter int FLOOR_Y     = 460,
    parameter int X_MAX       = 630,
    parameter int HOOP_Y      = 200,
    parameter int HOOP_X_LO   = 500,
    parameter int HOOP_X_HI   = 540,
    parameter int HOLD_FRAMES = 60
) (
    input  logic            clk,
    input  logic            reset,
    shot_sequencer_if.slave bus
);

    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic signed [10:0] C_START_X   = 11'(START_X);
    localparam logic signed [10:0] C_START_Y   = 11'(START_Y);
    localparam logic signed [10:0] C_FLOOR_Y   = 11'(FLOOR_Y);
    localparam logic signed [10:0] C_X_MAX     = 11'(X_MAX);
    localparam logic signed [10:0] C_HOOP_Y    = 11'(HOOP_Y);
    localparam logic signed [10:0] C_HOOP_X_LO = 11'(HOOP_X_LO);
    localparam logic signed [10:0] C_HOOP_X_HI = 11'(HOOP_X_HI);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLIGHT,
        S_HOLD
    } state_t;

    state_t                    r_state;
    logic signed [10:0]        r_x;
    logic signed [10:0]        r_y;
    logic signed [7:0]         r_vy;
    logic        [5:0]         r_vx;
    logic        [HOLD_W-1:0]  r_hold_cnt;
    logic        [9:0]         r_ball_x;
    logic        [9:0]         r_ball_y;
    logic                      r_in_flight;
    logic                      r_scored;
    logic                      r_missed;
    logic                      r_done;

    logic signed [10:0]        w_x_n;
    logic signed [10:0]        w_y_n;
    logic signed [7:0]         w_vy_n;
    logic                      w_hit_hoop;
    logic                      w_hit_floor;
    logic                      w_hit_edge;

    // Gravity pulls vy toward negative (downward); saturate instead of wrapping.
    function automatic logic signed [7:0] sat_vy_step(input logic signed [7:0] v);
        logic signed [8:0] d;
        d = $signed({v[7], v}) - $signed(9'(GRAVITY));
        if (d < -9'sd128)
            return -8'sd128;
        return d[7:0];
    endfunction

    function automatic logic [9:0] clip_y(input logic signed [10:0] y);
        if (y < 11'sd0)
            return 10'd0;
        return y[9:0];
    endfunction

    function automatic logic [9:0] clamp_x(input logic signed [10:0] x);
        if (x >= C_X_MAX)
            return 10'(X_MAX);
        return x[9:0];
    endfunction

    assign w_x_n  = r_x + $signed({5'b0, r_vx});
    assign w_y_n  = r_y - $signed({{3{r_vy[7]}}, r_vy});
    assign w_vy_n = sat_vy_step(r_vy);

    // A score needs the ball descending through the rim line inside the hoop span.
    assign w_hit_hoop  = (r_vy < 8'sd0) && (r_y < C_HOOP_Y) && (w_y_n >= C_HOOP_Y) &&
                         (w_x_n >= C_HOOP_X_LO) && (w_x_n <= C_HOOP_X_HI);
    assign w_hit_floor = (w_y_n >= C_FLOOR_Y);
    assign w_hit_edge  = (w_x_n >= C_X_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_x         <= C_START_X;
            r_y         <= C_START_Y;
            r_vy        <= 8'sd0;
            r_vx        <= 6'd0;
            r_hold_cnt  <= '0;
            r_ball_x    <= 10'(START_X);
            r_ball_y    <= 10'(START_Y);
            r_in_flight <= 1'b0;
            r_scored    <= 1'b0;
            r_missed    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.launch) begin
                        r_vx        <= bus.vx0;
                        r_vy        <= $signed({1'b0, bus.vy0});
                        r_x         <= C_START_X;
                        r_y         <= C_START_Y;
                        r_scored    <= 1'b0;
                        r_missed    <= 1'b0;
                        r_in_flight <= 1'b1;
                        r_state     <= S_FLIGHT;
                    end
                end
                S_FLIGHT: begin
                    if (bus.frame_tick) begin
                        if (w_hit_hoop) begin
                            r_scored    <= 1'b1;
                            r_ball_x    <= w_x_n[9:0];
                            r_ball_y    <= clip_y(w_y_n);
                            r_done      <= 1'b1;
                            r_in_flight <= 1'b0;
                            r_hold_cnt  <= '0;
                            r_state     <= S_HOLD;
                        end else if (w_hit_floor) begin
                            r_missed    <= 1'b1;
                            r_ball_x    <= clamp_x(w_x_n);
                            r_ball_y    <= 10'(FLOOR_Y);
                            r_done      <= 1'b1;
                            r_in_flight <= 1'b0;
                            r_hold_cnt  <= '0;
                            r_state     <= S_HOLD;
                        end else if (w_hit_edge) begin
                            r_missed    <= 1'b1;
                            r_ball_x    <= 10'(X_MAX);
                            r_ball_y    <= clip_y(w_y_n);
                            r_done      <= 1'b1;
                            r_in_flight <= 1'b0;
                            r_hold_cnt  <= '0;
                            r_state     <= S_HOLD;
                        end else begin
                            r_x      <= w_x_n;
                            r_y      <= w_y_n;
                            r_vy     <= w_vy_n;
                            r_ball_x <= w_x_n[9:0];
                            r_ball_y <= clip_y(w_y_n);
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.frame_tick) begin
                        if (r_hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) begin
                            r_hold_cnt <= '0;
                            r_x        <= C_START_X;
                            r_y        <= C_START_Y;
                            r_ball_x   <= 10'(START_X);
                            r_ball_y   <= 10'(START_Y);
                            r_state    <= S_IDLE;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ball_x    = r_ball_x;
    assign bus.ball_y    = r_ball_y;
    assign bus.in_flight = r_in_flight;
    assign bus.scored    = r_scored;
    assign bus.missed    = r_missed;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_shot_sequencer.sv
// Self-checking bench for shot_sequencer: directed scenarios plus random shots
// compared against a closed-form projectile model.
module tb_shot_sequencer;

    localparam int SX = 10, SY = 300, FLOOR = 460, XMAX = 630;
    localparam int HOOPY = 200, HLO = 500, HHI = 540, HOLD = 60;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    shot_sequencer_if bus ();

    shot_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Closed form: after n frames x = SX + vx*n, y = SY - vy*n + n(n-1)/2.
    function automatic int y_at(input int vy, input int n);
        return SY - vy * n + (n * (n - 1)) / 2;
    endfunction

    // Outcome of frame n (assuming the shot was still alive before it): 0 fly, 1 score, 2 miss.
    task automatic predict(input int vx, input int vy, input int n,
                           output int bx, output int by, output int oc);
        int xn, yn, yp, vpre;
        xn   = SX + vx * n;
        yn   = y_at(vy, n);
        yp   = y_at(vy, n - 1);
        vpre = vy - (n - 1);
        if (vpre < 0 && yp < HOOPY && yn >= HOOPY && xn >= HLO && xn <= HHI) begin
            oc = 1; bx = xn; by = yn;
        end else if (yn >= FLOOR) begin
            oc = 2; bx = (xn > XMAX) ? XMAX : xn; by = FLOOR;
        end else if (xn >= XMAX) begin
            oc = 2; bx = XMAX; by = (yn < 0) ? 0 : yn;
        end else begin
            oc = 0; bx = xn; by = (yn < 0) ? 0 : yn;
        end
    endtask

    task automatic tick();
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch_shot(input int vx, input int vy, input bit with_tick);
        @(negedge clk);
        bus.vx0 = 6'(vx);
        bus.vy0 = 7'(vy);
        bus.launch = 1'b1;
        bus.frame_tick = with_tick;
        @(negedge clk);
        bus.launch = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    task automatic fly(input int vx, input int vy, output int fx, output int fy, output int oc);
        int bx, by, o;
        bit ended;
        ended = 1'b0;
        fx = 0; fy = 0; oc = 0;
        for (int n = 1; n <= 200 && !ended; n++) begin
            predict(vx, vy, n, bx, by, o);
            tick();
            chk("ball_x", 32'(bus.ball_x), 32'(bx));
            chk("ball_y", 32'(bus.ball_y), 32'(by));
            chk("in_flight", 32'(bus.in_flight), (o == 0) ? 32'd1 : 32'd0);
            chk("done", 32'(bus.done), (o == 0) ? 32'd0 : 32'd1);
            if (o != 0) begin
                chk("scored", 32'(bus.scored), (o == 1) ? 32'd1 : 32'd0);
                chk("missed", 32'(bus.missed), (o == 2) ? 32'd1 : 32'd0);
                @(negedge clk);
                chk("done_pulse_end", 32'(bus.done), 32'd0);
                fx = bx; fy = by; oc = o; ended = 1'b1;
            end else begin
                gap($urandom_range(0, 3));
            end
        end
        if (!ended) chk("flight_timeout", 32'd0, 32'd1);
    endtask

    task automatic hold_out(input int fx, input int fy, input int sc, input int ms, input bit poke);
        for (int k = 1; k < HOLD; k++) begin
            if (poke && (k % 7) == 0) begin
                @(negedge clk);
                bus.vx0 = 6'($urandom_range(0, 63));
                bus.launch = 1'b1;
                @(negedge clk) bus.launch = 1'b0;
            end
            tick();
            chk("hold_x", 32'(bus.ball_x), 32'(fx));
            chk("hold_y", 32'(bus.ball_y), 32'(fy));
            chk("hold_flight", 32'(bus.in_flight), 32'd0);
            gap($urandom_range(0, 2));
        end
        tick();
        chk("rearm_x", 32'(bus.ball_x), 32'(SX));
        chk("rearm_y", 32'(bus.ball_y), 32'(SY));
        chk("rearm_scored", 32'(bus.scored), 32'(sc));
        chk("rearm_missed", 32'(bus.missed), 32'(ms));
        chk("rearm_flight", 32'(bus.in_flight), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fx, fy, oc, vx, vy;
        reset = 1'b1;
        bus.frame_tick = 1'b0;
        bus.launch = 1'b0;
        bus.vx0 = '0;
        bus.vy0 = '0;
        gap(3);
        chk("rst_x", 32'(bus.ball_x), 32'(SX));
        chk("rst_y", 32'(bus.ball_y), 32'(SY));
        chk("rst_flags", {28'd0, bus.in_flight, bus.scored, bus.missed, bus.done}, 32'd0);
        reset = 1'b0;
        gap(2);

        // Scenario 1: flat shot, frame_tick coincident with launch gives no motion.
        launch_shot(4, 0, 1'b1);
        chk("s1_launch_x", 32'(bus.ball_x), 32'(SX));
        chk("s1_launch_y", 32'(bus.ball_y), 32'(SY));
        chk("s1_in_flight", 32'(bus.in_flight), 32'd1);
        tick(); chk("s1_t1_x", 32'(bus.ball_x), 32'd14); chk("s1_t1_y", 32'(bus.ball_y), 32'd300);
        gap(4);
        chk("s1_frozen_x", 32'(bus.ball_x), 32'd14);
        tick(); chk("s1_t2_x", 32'(bus.ball_x), 32'd18); chk("s1_t2_y", 32'(bus.ball_y), 32'd301);
        tick(); chk("s1_t3_x", 32'(bus.ball_x), 32'd22); chk("s1_t3_y", 32'(bus.ball_y), 32'd303);
        chk("s1_t3_flight", 32'(bus.in_flight), 32'd1);
        tick(); tick();
        chk("s1_t5_x", 32'(bus.ball_x), 32'd30);
        chk("s1_t5_y", 32'(bus.ball_y), 32'd310);

        // Scenario 6: asynchronous reset mid-flight, then ticks without launch.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("s6_async_x", 32'(bus.ball_x), 32'(SX));
        chk("s6_async_y", 32'(bus.ball_y), 32'(SY));
        chk("s6_async_flags", {28'd0, bus.in_flight, bus.scored, bus.missed, bus.done}, 32'd0);
        @(negedge clk) reset = 1'b0;
        tick(); tick(); tick();
        chk("s6_idle_x", 32'(bus.ball_x), 32'(SX));
        chk("s6_idle_y", 32'(bus.ball_y), 32'(SY));
        chk("s6_idle_flight", 32'(bus.in_flight), 32'd0);

        // Scenario 2: dropped ball hits the floor on frame 19.
        launch_shot(0, 0, 1'b0);
        repeat (18) begin tick(); gap($urandom_range(0, 2)); end
        chk("s2_t18_y", 32'(bus.ball_y), 32'd453);
        chk("s2_t18_missed", 32'(bus.missed), 32'd0);
        tick();
        chk("s2_missed", 32'(bus.missed), 32'd1);
        chk("s2_floor_y", 32'(bus.ball_y), 32'(FLOOR));
        chk("s2_floor_x", 32'(bus.ball_x), 32'(SX));
        chk("s2_done", 32'(bus.done), 32'd1);
        chk("s2_flight", 32'(bus.in_flight), 32'd0);
        @(negedge clk) chk("s2_done_end", 32'(bus.done), 32'd0);
        hold_out(SX, FLOOR, 0, 1, 1'b0);

        // Scenarios 3 and 5: score, with launch held high during flight.
        launch_shot(14, 20, 1'b0);
        bus.launch = 1'b1;
        bus.vx0 = 6'd63;
        repeat (35) tick();
        chk("s3_t35_x", 32'(bus.ball_x), 32'd500);
        chk("s3_t35_y", 32'(bus.ball_y), 32'd195);
        tick();
        bus.launch = 1'b0;
        chk("s3_scored", 32'(bus.scored), 32'd1);
        chk("s3_missed", 32'(bus.missed), 32'd0);
        chk("s3_x", 32'(bus.ball_x), 32'd514);
        chk("s3_y", 32'(bus.ball_y), 32'd210);
        chk("s3_done", 32'(bus.done), 32'd1);
        hold_out(514, 210, 1, 0, 1'b1);
        launch_shot(4, 0, 1'b0);
        chk("s5_scored_cleared", 32'(bus.scored), 32'd0);
        chk("s5_in_flight", 32'(bus.in_flight), 32'd1);
        fly(4, 0, fx, fy, oc);
        hold_out(fx, fy, (oc == 1) ? 1 : 0, (oc == 2) ? 1 : 0, 1'b0);

        // Scenario 4: fast shot leaves through the right edge.
        launch_shot(63, 20, 1'b0);
        repeat (9) tick();
        chk("s4_t9_x", 32'(bus.ball_x), 32'd577);
        tick();
        chk("s4_missed", 32'(bus.missed), 32'd1);
        chk("s4_edge_x", 32'(bus.ball_x), 32'(XMAX));
        chk("s4_edge_y", 32'(bus.ball_y), 32'd145);
        chk("s4_scored", 32'(bus.scored), 32'd0);
        hold_out(XMAX, 145, 0, 1, 1'b1);

        // Random shots against the closed-form model.
        for (int s = 0; s < 8; s++) begin
            vx = $urandom_range(0, 63);
            vy = $urandom_range(0, 40);
            launch_shot(vx, vy, 1'($urandom_range(0, 1)));
            chk("rnd_launch_flight", 32'(bus.in_flight), 32'd1);
            fly(vx, vy, fx, fy, oc);
            hold_out(fx, fy, (oc == 1) ? 1 : 0, (oc == 2) ? 1 : 0, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
